// File: rtl/cicero_cmd_pkg.sv
// Shared opcodes, FSM state encoding and status-word bit positions for the
// CICERO host-command controller.
package cicero_cmd_pkg;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_WRITE_MEM    = 8'h01;
  localparam logic [7:0] OP_READ_MEM     = 8'h02;
  localparam logic [7:0] OP_START        = 8'h03;
  localparam logic [7:0] OP_ENGINE_RESET = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_MEM_WR   = 3'd2,
    S_MEM_RD   = 3'd3,
    S_START    = 3'd4,
    S_RUN      = 3'd5,
    S_ERST     = 3'd6,
    S_COMPLETE = 3'd7
  } state_e;

  localparam int ST_BUSY       = 0;
  localparam int ST_ENG_DONE   = 1;
  localparam int ST_ENG_ACCEPT = 2;
  localparam int ST_ERROR      = 3;
  localparam int ST_TIMEOUT    = 4;

  // True when no bit at or above position w is set.
  function automatic logic addr_fits(input logic [31:0] v, input int w);
    return (w >= 32) || ((v >> w) == 32'd0);
  endfunction

endpackage

// File: rtl/cicero_cmd_sync.sv
// N-bit two-flop synchronizer for the quasi-static JTAG-side words.
module cicero_cmd_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cicero_cmd_controller.sv
// Tag-triggered host-command sequencer driving CICERO code memory and regex engine.
// Define CICERO_CMD_TIMEOUT_EN to build the watchdog on memory/engine waits.
module cicero_cmd_controller
  import cicero_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           command,
  input  logic [31:0]           address,
  input  logic [31:0]           start_cc_pointer,
  input  logic [31:0]           end_cc_pointer,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [31:0]           status,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  engine_start,
  output logic                  engine_rst,
  output logic [ADDR_WIDTH-1:0] engine_start_cc,
  output logic [ADDR_WIDTH-1:0] engine_end_cc,
  input  logic                  engine_done,
  input  logic                  engine_accept
);

  logic [31:0]           cmd_s2, addr_s2, sc_s2, ec_s2;
  logic [DATA_WIDTH-1:0] data_s2;
  logic [31:0]           cmd_s3_q;

  cicero_cmd_sync #(.W(32)) u_sync_cmd (.clk(clk), .rst(rst), .d_i(command),          .q_o(cmd_s2));
  cicero_cmd_sync #(.W(32)) u_sync_adr (.clk(clk), .rst(rst), .d_i(address),          .q_o(addr_s2));
  cicero_cmd_sync #(.W(32)) u_sync_scc (.clk(clk), .rst(rst), .d_i(start_cc_pointer), .q_o(sc_s2));
  cicero_cmd_sync #(.W(32)) u_sync_ecc (.clk(clk), .rst(rst), .d_i(end_cc_pointer),   .q_o(ec_s2));
  cicero_cmd_sync #(.W(DATA_WIDTH)) u_sync_dat (.clk(clk), .rst(rst), .d_i(data_in), .q_o(data_s2));

  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            tag_q, tag_d;
  logic [7:0]            last_tag_q, last_tag_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           sc_q, sc_d;
  logic [31:0]           ec_q, ec_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  acc_q, acc_d;
  logic                  err_q, err_d;
  logic                  tmo_flag_q, tmo_flag_d;
  logic                  new_cmd;
  logic                  tmo_hit;

  // A command is taken only once the third register agrees with the second,
  // so a word caught mid-update in the JTAG domain is never acted on.
  assign new_cmd = (state_q == S_IDLE) && (cmd_s2 == cmd_s3_q) &&
                   (cmd_s2[15:8] != last_tag_q);

`ifdef CICERO_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_wait;

  assign in_wait = (state_q == S_MEM_WR) || (state_q == S_MEM_RD) || (state_q == S_RUN);

  // Every wait state is entered from a non-wait state, so the counter is
  // always zero on entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_wait) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = in_wait && (tmo_cnt_q >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    last_tag_d = last_tag_q;
    addr_d     = addr_q;
    sc_d       = sc_q;
    ec_d       = ec_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    acc_d      = acc_q;
    err_d      = err_q;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      S_IDLE: begin
        if (new_cmd) begin
          op_d       = cmd_s2[7:0];
          tag_d      = cmd_s2[15:8];
          addr_d     = addr_s2;
          sc_d       = sc_s2;
          ec_d       = ec_s2;
          wdata_d    = data_s2;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          tmo_flag_d = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_COMPLETE;
        case (op_q)
          OP_NOP: state_d = S_COMPLETE;
          OP_WRITE_MEM: begin
            if (addr_fits(addr_q, ADDR_WIDTH)) state_d = S_MEM_WR;
            else                               err_d   = 1'b1;
          end
          OP_READ_MEM: begin
            if (addr_fits(addr_q, ADDR_WIDTH)) state_d = S_MEM_RD;
            else                               err_d   = 1'b1;
          end
          OP_START: begin
            if (addr_fits(sc_q, ADDR_WIDTH) && addr_fits(ec_q, ADDR_WIDTH)) begin
              done_d  = 1'b0;
              state_d = S_START;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_ENGINE_RESET: state_d = S_ERST;
          default: err_d = 1'b1;
        endcase
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_COMPLETE;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = S_COMPLETE;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = S_COMPLETE;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = S_COMPLETE;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (engine_done) begin
          done_d  = 1'b1;
          acc_d   = engine_accept;
          state_d = S_COMPLETE;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          tmo_flag_d = 1'b1;
          state_d    = S_COMPLETE;
        end
      end
      S_ERST: begin
        done_d  = 1'b0;
        acc_d   = 1'b0;
        state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        last_tag_d = tag_q;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_s3_q   <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      last_tag_q <= '0;
      addr_q     <= '0;
      sc_q       <= '0;
      ec_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
      err_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_s3_q   <= cmd_s2;
      op_q       <= op_d;
      tag_q      <= tag_d;
      last_tag_q <= last_tag_d;
      addr_q     <= addr_d;
      sc_q       <= sc_d;
      ec_q       <= ec_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Strobes decode straight from state so a reset clears them on the next edge.
  assign mem_valid       = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
  assign mem_we          = (state_q == S_MEM_WR);
  assign mem_addr        = addr_q[ADDR_WIDTH-1:0];
  assign mem_wdata       = wdata_q;
  assign engine_start    = (state_q == S_START);
  assign engine_rst      = (state_q == S_ERST);
  assign engine_start_cc = sc_q[ADDR_WIDTH-1:0];
  assign engine_end_cc   = ec_q[ADDR_WIDTH-1:0];
  assign data_out        = rdata_q;

  always_comb begin
    status                = '0;
    status[ST_BUSY]       = busy_q;
    status[ST_ENG_DONE]   = done_q;
    status[ST_ENG_ACCEPT] = acc_q;
    status[ST_ERROR]      = err_q;
    status[ST_TIMEOUT]    = tmo_flag_q;
    status[15:8]          = last_tag_q;
  end

endmodule

// File: tb/tb_cicero_cmd_controller.sv
// Directed bench: stimulus queues expected memory/engine events and completions,
// a monitor pops and compares them as the controller produces them.
module tb_cicero_cmd_controller;

  localparam int AW = 12;
  localparam int DW = 64;

  localparam logic [2:0] EV_WR    = 3'd0;
  localparam logic [2:0] EV_RD    = 3'd1;
  localparam logic [2:0] EV_START = 3'd2;
  localparam logic [2:0] EV_ERST  = 3'd3;
  localparam logic [2:0] EV_DONE  = 3'd4;

  localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
  localparam logic [63:0] D2 = 64'h01234567_89ABCDEF;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] a;
    logic [63:0] b;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   command = '0, address = '0, start_cc_pointer = '0, end_cc_pointer = '0;
  logic [DW-1:0] data_in = '0;
  logic [31:0]   status;
  logic [DW-1:0] data_out;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          engine_start, engine_rst;
  logic [AW-1:0] engine_start_cc, engine_end_cc;
  logic          engine_done = 1'b0, engine_accept = 1'b0;

  ev_t   exp_q[$];
  int    checks = 0, errors = 0, done_cnt = 0, exp_done = 0;
  int    mem_lat = 0, mwait = 0;
  bit    mem_stuck = 1'b0;
  logic [63:0] marr [0:4095];
  int    eng_lat = 1, eng_cnt = 0;
  bit    eng_acc = 1'b0, eng_glitch = 1'b0, eng_armed = 1'b0;

  cicero_cmd_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .command(command), .address(address),
    .start_cc_pointer(start_cc_pointer), .end_cc_pointer(end_cc_pointer),
    .data_in(data_in), .status(status), .data_out(data_out),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .engine_start(engine_start), .engine_rst(engine_rst),
    .engine_start_cc(engine_start_cc), .engine_end_cc(engine_end_cc),
    .engine_done(engine_done), .engine_accept(engine_accept)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [63:0] a, input logic [63:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input logic [31:0] st, input logic [63:0] dout);
    expect_ev(EV_DONE, 64'(st), dout);
    exp_done++;
  endtask

  task automatic observe(input string name, input logic [2:0] k, input logic [63:0] a,
                         input logic [63:0] b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got %h/%h expected no event", name, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL %s: got kind %0d %h/%h expected kind %0d %h/%h",
                 name, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor
  initial begin
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        prev_busy = 1'b0;
        continue;
      end
      if (mem_valid && mem_ready)
        observe(mem_we ? "mem_wr" : "mem_rd", mem_we ? EV_WR : EV_RD, 64'(mem_addr),
                mem_we ? mem_wdata : 64'd0);
      if (engine_start) observe("engine_start", EV_START, 64'(engine_start_cc), 64'(engine_end_cc));
      if (engine_rst)   observe("engine_rst", EV_ERST, 64'd0, 64'd0);
      if (prev_busy && !status[0]) begin
        observe("completion", EV_DONE, 64'(status), data_out);
        done_cnt++;
      end
      prev_busy = status[0];
    end
  end

  // Memory model: ready after mem_lat idle cycles, or never while stuck.
  initial forever begin
    @(negedge clk);
    if (mem_valid && !mem_stuck && !rst) begin
      if (mwait >= mem_lat) begin
        mem_ready = 1'b1;
        if (mem_we) marr[mem_addr] = mem_wdata;
        else        mem_rdata = marr[mem_addr];
        mwait = 0;
      end else begin
        mem_ready = 1'b0;
        mwait++;
      end
    end else begin
      mem_ready = 1'b0;
      mwait = 0;
    end
  end

  // Engine model; in glitch mode it also raises done during the start pulse.
  initial forever begin
    @(negedge clk);
    engine_done = 1'b0;
    engine_accept = 1'b0;
    if (rst) begin
      eng_armed = 1'b0;
    end else if (engine_start) begin
      if (eng_glitch) begin
        engine_done = 1'b1;
        engine_accept = 1'b1;
      end
      eng_armed = 1'b1;
      eng_cnt = eng_lat;
    end else if (eng_armed) begin
      if (eng_cnt <= 1) begin
        engine_done = 1'b1;
        engine_accept = eng_acc;
        eng_armed = 1'b0;
      end else begin
        eng_cnt--;
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [7:0] tag, input logic [31:0] adr,
                       input logic [31:0] sc, input logic [31:0] ec, input logic [63:0] d);
    @(negedge clk);
    address = adr;
    start_cc_pointer = sc;
    end_cc_pointer = ec;
    data_in = d;
    command = {16'h0000, tag, op};
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < exp_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", name, done_cnt, exp_done);
      exp_done = done_cnt;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_strobes", {60'd0, mem_valid, mem_we, engine_start, engine_rst}, 64'd0);
    chk("reset_data_out", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    mem_lat = 2;
    expect_ev(EV_WR, 64'd5, D1);
    expect_done(32'h0000_0100, 64'd0);
    issue(8'h01, 8'h01, 32'd5, 32'd0, 32'd0, D1);
    wait_done("write");

    mem_lat = 3;
    expect_ev(EV_RD, 64'd5, 64'd0);
    expect_done(32'h0000_0200, D1);
    issue(8'h02, 8'h02, 32'd5, 32'd0, 32'd0, 64'd0);
    wait_done("read");

    eng_lat = 20; eng_acc = 1'b1;
    expect_ev(EV_START, 64'd0, 64'd10);
    expect_done(32'h0000_0306, D1);
    issue(8'h03, 8'h03, 32'd0, 32'd0, 32'd10, 64'd0);
    wait_done("start");

    expect_done(32'h0000_040E, D1);
    issue(8'h77, 8'h04, 32'd0, 32'd0, 32'd0, 64'd0);
    wait_done("illegal_op");

    expect_done(32'h0000_050E, D1);
    issue(8'h02, 8'h05, 32'h0000_1000, 32'd0, 32'd0, 64'd0);
    wait_done("read_oor");

    expect_ev(EV_ERST, 64'd0, 64'd0);
    expect_done(32'h0000_0600, D1);
    issue(8'h04, 8'h06, 32'd0, 32'd0, 32'd0, 64'd0);
    wait_done("engine_reset");

    // Input change -> DECODE after 4 edges, tag visible 2 edges later.
    expect_done(32'h0000_0700, D1);
    issue(8'h00, 8'h07, 32'd0, 32'd0, 32'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("nop_busy_edge3", 64'(status[0]), 64'd0);
    @(posedge clk);
    #1 chk("nop_busy_edge4", 64'(status[0]), 64'd1);
    @(posedge clk);
    #1 chk("nop_tag_edge5", 64'(status[15:8]), 64'h06);
    @(posedge clk);
    #1 chk("nop_status_edge6", 64'(status[15:0]), 64'h0700);
    wait_done("nop");

    expect_done(32'h0000_0808, D1);
    issue(8'h03, 8'h08, 32'd0, 32'd3, 32'h0000_1000, 64'd0);
    wait_done("start_oor");

    eng_glitch = 1'b1; eng_lat = 5; eng_acc = 1'b0;
    expect_ev(EV_START, 64'd1, 64'd2);
    expect_done(32'h0000_0902, D1);
    issue(8'h03, 8'h09, 32'd0, 32'd1, 32'd2, 64'd0);
    wait_done("start_glitch");
    eng_glitch = 1'b0;

    mem_lat = 0;
    expect_ev(EV_WR, 64'h0FFF, D2);
    expect_done(32'h0000_0A02, D1);
    issue(8'h01, 8'h0A, 32'h0000_0FFF, 32'd0, 32'd0, D2);
    wait_done("write_top");

    expect_ev(EV_RD, 64'h0FFF, 64'd0);
    expect_done(32'h0000_0B02, D2);
    issue(8'h02, 8'h0B, 32'h0000_0FFF, 32'd0, 32'd0, 64'd0);
    wait_done("read_top");

    mem_stuck = 1'b1;
    issue(8'h02, 8'h0C, 32'd7, 32'd0, 32'd0, 64'd0);
    vc = 0;
    while (!mem_valid && vc < 20) begin
      @(negedge clk);
      vc++;
    end
    chk("abort_read_started", 64'(mem_valid), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    command = 32'h0000_0001;
    @(posedge clk);
    #1;
    chk("abort_strobes", {60'd0, mem_valid, mem_we, engine_start, engine_rst}, 64'd0);
    chk("abort_status", 64'(status), 64'd0);
    chk("abort_data_out", data_out, 64'd0);
    chk("abort_mem_bus", {40'd0, mem_addr, 12'd0} | mem_wdata, 64'd0);
    chk("abort_engine_cc", {40'd0, engine_start_cc, engine_end_cc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_stuck = 1'b0;
    exp_q.delete();
    exp_done = done_cnt;
    repeat (12) @(negedge clk);
    chk("tag0_ignored", 64'(status), 64'd0);

    expect_done(32'h0000_0100, 64'd0);
    issue(8'h00, 8'h01, 32'd0, 32'd0, 32'd0, 64'd0);
    wait_done("tag1_after_reset");

`ifdef CICERO_CMD_TIMEOUT_EN
    mem_stuck = 1'b1;
    expect_done(32'h0000_0218, 64'd0);
    issue(8'h02, 8'h02, 32'd3, 32'd0, 32'd0, 64'd0);
    vc = 0;
    for (int n = 0; n < 100 && done_cnt < exp_done; n++) begin
      @(negedge clk);
      if (mem_valid) vc++;
    end
    chk("timeout_valid_cycles", 64'(vc), 64'd16);
    wait_done("timeout");
    mem_stuck = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
